ysyx_23060042_inst_encoder: RTL and testbench
=============================================

Name: ysyx_23060042_inst_encoder

Overview:
- Inverse of the instruction decode stage: accepts decoded instruction fields and packs them into 32-bit RV32I instruction words.
- Queues encoded words in a small FIFO.
- Streams each word out with a sequential word address for loading instruction memory, e.g. by a self-test or boot loader path.
- Flags immediates that do not fit the selected format.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- BASE_ADDR, 32'h8000_0000, address attached to the first word output after reset or clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: empties FIFO, restarts addresses.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept; equals !full.
- in_imm_type  in  3  000 R, 001 I, 010 S, 011 SB, 110 U, 111 UJ.
- in_opcode  in  7  major opcode.
- in_func3  in  3  minor opcode.
- in_func7  in  7  R-type inst[31:25].
- in_rs1 / in_rs2 / in_rd  in  5 each  register indices.
- in_imm  in  32  full sign-extended immediate value.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_inst  out  32  encoded instruction at head.
- out_err  out  1  head entry had an illegal immediate or type.
- out_addr  out  32  BASE_ADDR + 4*words_popped.
- level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0, async): FIFO empty, level=0, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, in_ready=1 once released.
- Push occurs on a rising edge with in_valid&&in_ready. Pop occurs on a rising edge with out_valid&&out_ready.
- Encoding is combinational from the in_* fields and is written at the push edge. Fixed fields: opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20].
  - R: func7 in [31:25].
  - I: imm[11:0] in [31:20]; rs2 not used.
  - S: imm[11:5] in [31:25], imm[4:0] in [11:7].
  - SB: imm[12] [31], imm[10:5] [30:25], imm[4:1] [11:8], imm[11] [7].
  - U: imm[31:12] in [31:12].
  - UJ: imm[20] [31], imm[10:1] [30:21], imm[11] [20], imm[19:12] [19:12].
  - Fields a format does not use are ignored.
- Legality check, setting err=1:
  - I/S: imm is not the sign extension of imm[11:0].
  - SB: imm is not the sign extension of imm[12:0], or imm[0]=1.
  - UJ: imm is not the sign extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0]≠0.
  - in_imm_type is 100 or 101.
  - R: never an error.
- On err the stored inst is 32'h0000_0000. The entry is still queued and still consumes an address.
- Latency: a word pushed into an empty FIFO at edge N shows out_valid=1 after edge N (first-word fall-through from storage). There is no combinational in→out bypass.
- out_inst/out_err hold while out_valid&&!out_ready.
- Full (level=DEPTH): in_ready=0. A push is impossible even with a simultaneous pop; in_ready rises the cycle after the pop.
- Empty: out_valid=0. out_inst/out_err are don't-care but stable.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, order preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately.
- out_addr increments by 4 on each pop and wraps modulo 2^32.
- clear=1 at an edge: level=0, pointers=0, out_addr=BASE_ADDR. A push or pop in the same cycle is discarded; clear has priority.
- Reset mid-stream discards all entries immediately. No partial word is ever output.

Decomposition:
- Shared package: imm_type localparams (R/I/S/SB/U/UJ codes, matching the decoder's imm_type encoding) and opcode constants (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
- One sub-module, ysyx_23060042_inst_fifo: a generic DEPTH×WIDTH fall-through FIFO with clear, used with WIDTH=33 ({err, inst}).
- Packing and the legality check stay combinational in the top.

Test Plan:
- addi x1,x0,5 (I, op 0010011, f3 0, rd 1, imm 5) → out_inst=0x00500093, err=0, out_addr=0x80000000.
- add x3,x1,x2 (R, op 0110011, f7 0) then sw x2,8(x1) (S, op 0100011, f3 010) → 0x002081B3 at 0x80000000, then 0x0020A423 at 0x80000004.
- lui x5 imm 0x12345000 (U, op 0110111) → 0x123452B7. jal x1,+16 (UJ, op 1101111) → 0x010000EF.
- Illegal inputs, each → out_inst=0, out_err=1, address still advances:
  - I-type with imm=0x800.
  - SB-type with imm=3.
  - in_imm_type=100.
- Backpressure, out_ready=0, DEPTH=4, push 5 words → in_ready=0 after 4th push, level=4. Release out_ready → words emerge in order; 5th word accepted the cycle after the first pop.
- Assert clear with level=3, or pulse rst_n low mid-stream → level=0, out_valid=0, next output address 0x80000000.

Source files
------------

// File: rtl/ysyx_23060042_inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: immediate format codes
// (same encoding as the decoder's imm_type) and major opcodes.
package ysyx_23060042_inst_encoder_pkg;

    localparam logic [2:0] IMM_R  = 3'b000;
    localparam logic [2:0] IMM_I  = 3'b001;
    localparam logic [2:0] IMM_S  = 3'b010;
    localparam logic [2:0] IMM_SB = 3'b011;
    localparam logic [2:0] IMM_U  = 3'b110;
    localparam logic [2:0] IMM_UJ = 3'b111;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // True when value equals the sign extension of its low `width` bits:
    // everything from bit width-1 upward must be all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
        logic [31:0] upper;
        upper = $signed(value) >>> (width - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/ysyx_23060042_inst_fifo.sv
// Generic DEPTH x WIDTH first-word fall-through FIFO with synchronous clear.
// The head entry is read straight from storage; occupancy is tracked separately.
module ysyx_23060042_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (level != LW'(DEPTH));
    assign pop_valid  = (level != '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];

    // Clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is zeroed on reset so the head reads as all zeros until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_23060042_inst_encoder.sv
// Packs decoded RV32I fields into instruction words, queues them, and streams
// them out with sequential word addresses; illegal immediates become a zero word with err set.
module ysyx_23060042_inst_encoder
    import ysyx_23060042_inst_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_imm_type,
    input  logic [6:0]              in_opcode,
    input  logic [2:0]              in_func3,
    input  logic [6:0]              in_func7,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [4:0]              in_rd,
    input  logic [31:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic                    out_err,
    output logic [31:0]             out_addr,
    output logic [$clog2(DEPTH):0]  level
);

    logic [31:0] enc_inst;
    logic        enc_err;
    logic [32:0] head;

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (in_imm_type)
            IMM_R: begin
                enc_inst = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
            end
            IMM_I: begin
                enc_inst = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
                enc_err  = !fits_signed(in_imm, 12);
            end
            IMM_S: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
                enc_err  = !fits_signed(in_imm, 12);
            end
            IMM_SB: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = !fits_signed(in_imm, 13) || in_imm[0];
            end
            IMM_U: begin
                enc_inst = {in_imm[31:12], in_rd, in_opcode};
                enc_err  = (in_imm[11:0] != 12'h000);
            end
            IMM_UJ: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err  = !fits_signed(in_imm, 21) || in_imm[0];
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_inst = '0;
        end
    end

    ysyx_23060042_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({enc_err, enc_inst}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head),
        .level      (level)
    );

    assign out_err  = head[32];
    assign out_inst = head[31:0];

    // One word address per popped entry, including error entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE_ADDR;
        end else if (clear) begin
            out_addr <= BASE_ADDR;
        end else if (out_valid && out_ready) begin
            out_addr <= out_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_ysyx_23060042_inst_encoder.sv
// Self-checking bench: directed RV32I encodings plus randomized traffic against
// an arithmetic reference encoder and a queue model of the FIFO and address counter.
module tb_ysyx_23060042_inst_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_type;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [31:0] out_addr;
    logic [2:0]  level;

    int          checks = 0;
    int          passes = 0;
    logic [32:0] model_q[$];
    logic [31:0] model_addr;

    ysyx_23060042_inst_encoder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm_type (in_imm_type),
        .in_opcode   (in_opcode),
        .in_func3    (in_func3),
        .in_func7    (in_func7),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_err     (out_err),
        .out_addr    (out_addr),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic longint unsigned fld(input longint unsigned v, input int lo, input int n);
        return (v >> lo) % (64'd1 << n);
    endfunction

    // Reference encoder built from signed ranges and shifted field sums.
    function automatic logic [32:0] refEncode(input logic [2:0] t, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [4:0] rd, input logic [31:0] imm);
        longint          sv;
        longint unsigned u, o, d, g, s1, s2, h, w;
        bit              err;
        sv  = longint'($signed(imm));
        u   = 64'(imm);
        o   = 64'(op);
        d   = 64'(rd);
        g   = 64'(f3);
        s1  = 64'(rs1);
        s2  = 64'(rs2);
        h   = 64'(f7);
        w   = 0;
        err = 1'b0;
        case (t)
            3'd0: w = o + (d << 7) + (g << 12) + (s1 << 15) + (s2 << 20) + (h << 25);
            3'd1: begin
                err = (sv < -2048) || (sv > 2047);
                w   = o + (d << 7) + (g << 12) + (s1 << 15) + (fld(u, 0, 12) << 20);
            end
            3'd2: begin
                err = (sv < -2048) || (sv > 2047);
                w   = o + (fld(u, 0, 5) << 7) + (g << 12) + (s1 << 15) + (s2 << 20) + (fld(u, 5, 7) << 25);
            end
            3'd3: begin
                err = (sv < -4096) || (sv > 4095) || (sv % 2 != 0);
                w   = o + (fld(u, 11, 1) << 7) + (fld(u, 1, 4) << 8) + (g << 12) + (s1 << 15)
                        + (s2 << 20) + (fld(u, 5, 6) << 25) + (fld(u, 12, 1) << 31);
            end
            3'd6: begin
                err = (u % 4096) != 0;
                w   = o + (d << 7) + ((u / 4096) << 12);
            end
            3'd7: begin
                err = (sv < -(64'sd1 << 20)) || (sv >= (64'sd1 << 20)) || (sv % 2 != 0);
                w   = o + (d << 7) + (fld(u, 12, 8) << 12) + (fld(u, 11, 1) << 20)
                        + (fld(u, 1, 10) << 21) + (fld(u, 20, 1) << 31);
            end
            default: err = 1'b1;
        endcase
        if (err) w = 0;
        return {err, w[31:0]};
    endfunction

    function automatic void modelReset();
        model_q.delete();
        model_addr = BASE;
    endfunction

    // Called just after each rising edge, using the inputs that were stable at it.
    function automatic void modelUpdate();
        bit          do_push;
        bit          do_pop;
        logic [32:0] e;
        if (clear) begin
            modelReset();
            return;
        end
        do_pop  = out_ready && (model_q.size() > 0);
        do_push = in_valid && (model_q.size() < DEPTH);
        e = refEncode(in_imm_type, in_opcode, in_func3, in_func7, in_rs1, in_rs2, in_rd, in_imm);
        if (do_pop) begin
            void'(model_q.pop_front());
            model_addr = model_addr + 32'd4;
        end
        if (do_push) model_q.push_back(e);
    endfunction

    task automatic compareAll();
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
        checkOutput("level", 32'(level), 32'(model_q.size()));
        checkOutput("out_addr", out_addr, model_addr);
        if (model_q.size() != 0) begin
            checkOutput("out_inst", out_inst, model_q[0][31:0]);
            checkOutput("out_err", 32'(out_err), 32'(model_q[0][32]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        compareAll();
    endtask

    task automatic applyStimulus(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm);
        in_imm_type = t;
        in_opcode   = op;
        in_func3    = f3;
        in_func7    = f7;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_imm      = imm;
    endtask

    task automatic pushOne(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] imm);
        applyStimulus(t, op, f3, f7, rs1, rs2, rd, imm);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] randImm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return {{20{r[11]}}, r[11:0]};
            1:       return {{19{r[12]}}, r[12:1], 1'b0};
            2:       return {{11{r[20]}}, r[20:1], 1'b0};
            3:       return {r[31:12], 12'h000};
            4:       return r;
            default: return {28'h0, r[3:0]};
        endcase
    endfunction

    task automatic randomStimulus();
        applyStimulus(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
                      5'($urandom), 5'($urandom), 5'($urandom), randImm());
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 3) != 0;
        clear     = ($urandom % 64) == 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        modelReset();

        repeat (2) @(negedge clk);
        compareAll();
        checkOutput("reset_inst", out_inst, 32'h0);
        checkOutput("reset_err", 32'(out_err), 32'h0);
        checkOutput("reset_addr", out_addr, BASE);
        rst_n = 1'b1;
        cycle();
        checkOutput("ready_after_reset", 32'(in_ready), 32'h1);

        // addi x1,x0,5
        pushOne(3'b001, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        checkOutput("addi_inst", out_inst, 32'h0050_0093);
        checkOutput("addi_err", 32'(out_err), 32'h0);
        checkOutput("addi_addr", out_addr, 32'h8000_0000);
        popOne();

        // add x3,x1,x2 then sw x2,8(x1); imm on add is junk and must be ignored
        doClear();
        pushOne(3'b000, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        pushOne(3'b010, 7'b0100011, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        checkOutput("add_inst", out_inst, 32'h0020_81B3);
        checkOutput("add_addr", out_addr, 32'h8000_0000);
        popOne();
        checkOutput("sw_inst", out_inst, 32'h0020_A423);
        checkOutput("sw_addr", out_addr, 32'h8000_0004);
        popOne();

        // lui x5,0x12345 and jal x1,+16
        pushOne(3'b110, 7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
        pushOne(3'b111, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd16);
        checkOutput("lui_inst", out_inst, 32'h1234_52B7);
        popOne();
        checkOutput("jal_inst", out_inst, 32'h0100_00EF);
        popOne();

        // Illegal entries still queue and consume addresses
        doClear();
        pushOne(3'b001, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800);
        pushOne(3'b011, 7'b1100011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        pushOne(3'b100, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("illegal_err", 32'(out_err), 32'h1);
            checkOutput("illegal_inst", out_inst, 32'h0);
            checkOutput("illegal_addr", out_addr, BASE + 32'(4 * k));
            popOne();
        end

        // Backpressure: fill, hold a fifth word, release one pop
        doClear();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'(i + 1), 32'd0);
            cycle();
        end
        checkOutput("bp_level_full", 32'(level), 32'd4);
        checkOutput("bp_ready_full", 32'(in_ready), 32'h0);
        applyStimulus(3'b000, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd5, 32'd0);
        cycle();
        checkOutput("bp_level_held", 32'(level), 32'd4);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checkOutput("bp_level_after_pop", 32'(level), 32'd3);
        checkOutput("bp_ready_after_pop", 32'(in_ready), 32'h1);
        cycle();
        in_valid = 1'b0;
        checkOutput("bp_level_refill", 32'(level), 32'd4);
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;
        checkOutput("bp_drained", 32'(level), 32'd0);

        // Clear at level 3 beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            pushOne(3'b001, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'(i), 32'(i));
        end
        checkOutput("clr_level_before", 32'(level), 32'd3);
        clear     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("clr_level", 32'(level), 32'd0);
        checkOutput("clr_valid", 32'(out_valid), 32'h0);
        checkOutput("clr_addr", out_addr, BASE);

        // Asynchronous reset mid-stream
        pushOne(3'b000, 7'b0110011, 3'd1, 7'd32, 5'd4, 5'd5, 5'd6, 32'd0);
        pushOne(3'b000, 7'b0110011, 3'd2, 7'd0, 5'd7, 5'd8, 5'd9, 32'd0);
        popOne();
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_addr", out_addr, BASE);
        @(negedge clk);
        rst_n = 1'b1;
        pushOne(3'b001, 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        checkOutput("rst_next_addr", out_addr, 32'h8000_0000);
        popOne();

        // Randomized traffic
        repeat (3000) begin
            randomStimulus();
            cycle();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
